sst_engine: RTL and testbench

- Initiator side of the mapper save-state (SST) register bus.
- On save: asserts sst_act, walks register indices 0..REG_CNT-1, samples each mapper's sst_di and streams the bytes out.
- On restore: accepts a byte stream and commits each byte into the mapper with sst_we_reg, timed against M2 falling edges, because mappers latch SST writes on negedge M2.
- Sits between the host/save-state memory streamer and the mapper slot's SST bus.

---
 rtl/sst_engine_if.sv | 34 +++
 rtl/sst_engine.sv | 239 +++++++++++++++++++++++
 tb/tb_sst_engine.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sst_engine_if.sv
// SST engine signal bundle: host control, mapper SST bus and the two byte streams.
// master = the engine (initiator), slave = host, streamer and mapper side.
interface sst_engine_if;
  logic       start;
  logic       mode;
  logic       m2;
  logic [7:0] map_idx;
  logic       busy;
  logic       done;
  logic       err;
  logic       sst_act;
  logic [7:0] sst_addr;
  logic       sst_we_reg;
  logic [7:0] sst_dato;
  logic [7:0] sst_di;
  logic [7:0] so_data;
  logic       so_valid;
  logic       so_ready;
  logic [7:0] si_data;
  logic       si_valid;
  logic       si_ready;

  modport master (
    input  start, mode, m2, map_idx, sst_di, so_ready, si_data, si_valid,
    output busy, done, err, sst_act, sst_addr, sst_we_reg, sst_dato,
           so_data, so_valid, si_ready
  );

  modport slave (
    output start, mode, m2, map_idx, sst_di, so_ready, si_data, si_valid,
    input  busy, done, err, sst_act, sst_addr, sst_we_reg, sst_dato,
           so_data, so_valid, si_ready
  );
endinterface

// File: rtl/sst_engine.sv
// Save-state initiator: walks the mapper SST register file for save (streaming
// bytes out) or restore (committing streamed bytes, one per M2 falling edge).
module sst_engine #(
  parameter int REG_CNT = 128,
  parameter int M2_SYNC = 2,
  parameter int TIMEOUT = 4096
) (
  input logic        clk,
  input logic        rst_n,
  sst_engine_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTER, S_SV_RD, S_SV_PUSH, S_RS_GET, S_RS_WR, S_RS_HOLD, S_EXIT
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(REG_CNT - 1);
  localparam int AW = $clog2(M2_SYNC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  // Falls already inside the synchronizer when the bus changes must be ignored.
  // Together with the cycle in which the change is decided, loading M2_SYNC
  // here blanks M2_SYNC+1 clk of fall detection.
  localparam logic [AW-1:0] ARM_LOAD = AW'(M2_SYNC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [7:0]    idx_q, idx_d;
  logic [AW-1:0] arm_q, arm_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          act_q, act_d;
  logic [7:0]    addr_q, addr_d;
  logic          we_q, we_d;
  logic [7:0]    dato_q, dato_d;
  logic [7:0]    so_data_q, so_data_d;

  logic [M2_SYNC-1:0] m2_sync_q;
  logic               m2_prev_q;
  logic               m2_fall;
  logic               fall_ok;
  logic               tmo_hit;
  logic               in_wait;

  // Synchronize the asynchronous M2 and keep the previous sample for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_sync_q <= '0;
      m2_prev_q <= 1'b0;
    end else begin
      m2_sync_q[0] <= bus.m2;
      for (int i = 1; i < M2_SYNC; i++) begin
        m2_sync_q[i] <= m2_sync_q[i-1];
      end
      m2_prev_q <= m2_sync_q[M2_SYNC-1];
    end
  end

  assign m2_fall = m2_prev_q & ~m2_sync_q[M2_SYNC-1];
  assign in_wait = (state_q == S_ENTER) || (state_q == S_RS_WR) || (state_q == S_EXIT);
  assign fall_ok = (arm_q == '0) && m2_fall;
  assign tmo_hit = !fall_ok && (tmo_q == TMO_LAST);

  // State and datapath registers; reset drops act/we instantly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      idx_q     <= '0;
      arm_q     <= '0;
      tmo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      act_q     <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      dato_q    <= '0;
      so_data_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      arm_q     <= arm_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      act_q     <= act_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      dato_q    <= dato_d;
      so_data_q <= so_data_d;
    end
  end

  // Next-state logic: sequencing, M2 waits with timeout, stream handshakes
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    arm_d     = (arm_q != '0) ? arm_q - AW'(1) : arm_q;
    tmo_d     = in_wait ? tmo_q + TW'(1) : tmo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    act_d     = act_q;
    addr_d    = addr_q;
    we_d      = we_q;
    dato_d    = dato_q;
    so_data_d = so_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          idx_d   = '0;
          addr_d  = '0;
          act_d   = 1'b1;
          arm_d   = ARM_LOAD;
          tmo_d   = '0;
          state_d = S_ENTER;
        end
      end

      S_ENTER: begin
        if (fall_ok) begin
          if (mode_q) begin
            state_d = S_RS_GET;
          end else begin
            addr_d  = idx_q;
            state_d = S_SV_RD;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          act_d   = 1'b0;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      // sst_addr has been stable for this whole clk; the mapper read is combinational
      S_SV_RD: begin
        so_data_d = bus.sst_di;
        state_d   = S_SV_PUSH;
      end

      S_SV_PUSH: begin
        if (bus.so_ready) begin
          if (idx_q == LAST_IDX) begin
            arm_d   = ARM_LOAD;
            tmo_d   = '0;
            state_d = S_EXIT;
          end else begin
            idx_d   = idx_q + 8'd1;
            addr_d  = idx_q + 8'd1;
            state_d = S_SV_RD;
          end
        end
      end

      S_RS_GET: begin
        if (bus.si_valid) begin
          if (idx_q == LAST_IDX) begin
            // Last slot holds the mapper id: verify only, never write it
            if (bus.si_data != bus.map_idx) begin
              err_d = 1'b1;
            end
            arm_d   = ARM_LOAD;
            tmo_d   = '0;
            state_d = S_EXIT;
          end else begin
            addr_d  = idx_q;
            dato_d  = bus.si_data;
            we_d    = 1'b1;
            arm_d   = ARM_LOAD;
            tmo_d   = '0;
            state_d = S_RS_WR;
          end
        end
      end

      S_RS_WR: begin
        if (fall_ok) begin
          we_d    = 1'b0;
          state_d = S_RS_HOLD;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          act_d   = 1'b0;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      // Strobe is low, address/data still held for the mapper's hold time
      S_RS_HOLD: begin
        idx_d   = idx_q + 8'd1;
        state_d = S_RS_GET;
      end

      S_EXIT: begin
        we_d = 1'b0;
        if (fall_ok || tmo_hit) begin
          if (tmo_hit) begin
            err_d = 1'b1;
          end
          act_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.sst_act    = act_q;
  assign bus.sst_addr   = addr_q;
  assign bus.sst_we_reg = we_q;
  assign bus.sst_dato   = dato_q;
  assign bus.so_data    = so_data_q;
  assign bus.so_valid   = (state_q == S_SV_PUSH);
  assign bus.si_ready   = (state_q == S_RS_GET);

endmodule

// File: tb/tb_sst_engine.sv
// Bench for sst_engine: mapper model latching on negedge M2, stream source/sink,
// and a per-cycle compare process checking outputs against expected streams.
module tb_sst_engine;
  localparam int REG_CNT = 128;
  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sst_engine_if bus();

  sst_engine #(.REG_CNT(REG_CNT), .M2_SYNC(2), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Mapper read model: register value is its index xor 0x5A
  assign bus.sst_di = bus.sst_addr ^ 8'h5A;

  int n_assert = 0;
  int n_fail   = 0;

  bit m2_run   = 1'b1;
  bit tb_clear = 1'b0;
  bit rdy_mode = 1'b0;
  int m2_ph    = 0;
  int cyc      = 0;

  logic [7:0] rs_stream [REG_CNT];
  logic [7:0] save_log  [REG_CNT];
  int         save_cnt  = 0;
  int         rs_pos    = 0;
  bit         rs_pend   = 1'b0;

  int         wr_cnt  [REG_CNT];
  int         wr_base [REG_CNT];
  logic [7:0] wr_data [REG_CNT];
  int         wr_total = 0;
  int         base_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // M2 at 1/12 of clk, edges placed away from clk edges; freezes when m2_run=0
  initial begin
    bus.m2 = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      if (m2_run) begin
        m2_ph  = (m2_ph == 11) ? 0 : m2_ph + 1;
        bus.m2 = (m2_ph < 6);
      end
    end
  end

  // Mapper write model: latches the SST write on M2 falling edge
  initial begin
    forever begin
      @(negedge bus.m2);
      if (rst_n === 1'b1 && bus.sst_act === 1'b1 && bus.sst_we_reg === 1'b1) begin
        wr_cnt[bus.sst_addr[6:0]]++;
        wr_data[bus.sst_addr[6:0]] = bus.sst_dato;
        wr_total++;
      end
    end
  end

  // Stream source/sink and per-cycle compare against the expected streams
  initial begin
    bus.so_ready = 1'b0;
    bus.si_valid = 1'b0;
    bus.si_data  = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (tb_clear) begin
        save_cnt = 0;
        rs_pos   = 0;
        rs_pend  = 1'b0;
      end else if (rs_pend) begin
        rs_pos++;
        rs_pend = 1'b0;
      end
      bus.so_ready = (!rdy_mode) || (cyc % 3 == 0);
      bus.si_valid = (rs_pos < REG_CNT);
      bus.si_data  = (rs_pos < REG_CNT) ? rs_stream[rs_pos[6:0]] : 8'h00;
      if (rst_n) begin
        if (bus.so_valid) begin
          chk("so_data", int'(bus.so_data), (save_cnt ^ 32'h5A) & 32'hFF);
          if (bus.so_ready) begin
            if (save_cnt < REG_CNT) save_log[save_cnt[6:0]] = bus.so_data;
            save_cnt++;
          end
        end
        if (bus.si_ready && bus.si_valid) rs_pend = 1'b1;
        if (bus.sst_we_reg) begin
          chk("we_needs_act", int'(bus.sst_act), 1);
          chk("we_addr_not_last", int'(bus.sst_addr != 8'(REG_CNT - 1)), 1);
          chk("we_dato", int'(bus.sst_dato), int'(rs_stream[bus.sst_addr[6:0]]));
        end
        if (bus.so_valid || bus.si_ready) begin
          chk("stream_exclusive", int'(bus.so_valid && bus.si_ready), 0);
          chk("busy_during_op", int'(bus.busy), 1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    tb_clear = 1'b1;
    tick(2);
    tb_clear = 1'b0;
  endtask

  task automatic snap();
    for (int i = 0; i < REG_CNT; i++) wr_base[i] = wr_cnt[i];
    base_total = wr_total;
  endtask

  task automatic pulse_start(input bit m);
    bus.mode  = m;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input bit exp_err,
                           output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < budget) begin
      tick(1);
      cycles++;
    end
    chk({name, "_done_seen"}, int'(bus.done === 1'b1), 1);
    chk({name, "_err"}, int'(bus.err), int'(exp_err));
    chk({name, "_act_low"}, int'(bus.sst_act), 0);
    chk({name, "_we_low"}, int'(bus.sst_we_reg), 0);
    chk({name, "_busy_low"}, int'(bus.busy), 0);
    tick(1);
    chk({name, "_done_one_clk"}, int'(bus.done), 0);
  endtask

  // Indices below n must be written exactly once with the streamed byte; the rest never
  task automatic check_writes(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < REG_CNT; i++) begin
      int d;
      bit ok;
      d  = wr_cnt[i] - wr_base[i];
      ok = (i < n) ? (d == 1 && wr_data[i] === rs_stream[i]) : (d == 0);
      if (!ok) bad++;
    end
    chk({name, "_bad_write_indices"}, bad, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int waited;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.mode    = 1'b0;
    bus.map_idx = 8'h25;
    for (int i = 0; i < REG_CNT; i++) rs_stream[i] = 8'(i * 37 + 11);
    rs_stream[0]   = 8'h34;
    rs_stream[1]   = 8'h81;
    rs_stream[127] = 8'd72;
    tick(3);

    // Reset state
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_act", int'(bus.sst_act), 0);
    chk("rst_we", int'(bus.sst_we_reg), 0);
    chk("rst_addr", int'(bus.sst_addr), 0);
    chk("rst_dato", int'(bus.sst_dato), 0);
    chk("rst_so_valid", int'(bus.so_valid), 0);
    chk("rst_so_data", int'(bus.so_data), 0);
    chk("rst_si_ready", int'(bus.si_ready), 0);
    rst_n = 1'b1;
    clear_log();

    // Save, always-ready sink; a start while busy must be ignored
    snap();
    pulse_start(1'b0);
    tick(30);
    chk("save_act_mid", int'(bus.sst_act), 1);
    chk("save_busy_mid", int'(bus.busy), 1);
    pulse_start(1'b1);
    wait_done("save_ready", 3000, 1'b0, cycles);
    chk("save_ready_count", save_cnt, 128);
    chk("save_ready_b0", int'(save_log[0]), 'h5A);
    chk("save_ready_b1", int'(save_log[1]), 'h5B);
    chk("save_ready_b127", int'(save_log[127]), 'h25);
    chk("save_no_writes", wr_total - base_total, 0);

    // Save with sink ready 1 of 3 cycles
    rdy_mode = 1'b1;
    clear_log();
    pulse_start(1'b0);
    wait_done("save_stall", 4000, 1'b0, cycles);
    chk("save_stall_count", save_cnt, 128);
    chk("save_stall_b64", int'(save_log[64]), 'h1A);
    chk("save_stall_b127", int'(save_log[127]), 'h25);
    rdy_mode = 1'b0;

    // Restore, id byte matches
    bus.map_idx = 8'd72;
    snap();
    clear_log();
    pulse_start(1'b1);
    wait_done("restore_ok", 8000, 1'b0, cycles);
    check_writes("restore_ok", 127);
    chk("restore_ok_reg0", int'(wr_data[0]), 'h34);
    chk("restore_ok_reg1", int'(wr_data[1]), 'h81);
    chk("restore_ok_consumed", rs_pos, 128);

    // Restore, id byte mismatch
    rs_stream[127] = 8'h5C;
    snap();
    clear_log();
    pulse_start(1'b1);
    wait_done("restore_badid", 8000, 1'b1, cycles);
    check_writes("restore_badid", 127);
    rs_stream[127] = 8'd72;

    // M2 stops after 5 writes: timeout
    snap();
    clear_log();
    pulse_start(1'b1);
    tick(1);
    chk("err_cleared_on_start", int'(bus.err), 0);
    chk("busy_after_start", int'(bus.busy), 1);
    waited = 0;
    while (wr_total - base_total < 5 && waited < 2000) begin
      tick(1);
      waited++;
    end
    chk("tmo_five_writes_seen", int'(wr_total - base_total >= 5), 1);
    m2_run = 1'b0;
    wait_done("timeout", 6000, 1'b1, cycles);
    chk("timeout_window", int'(cycles >= TIMEOUT && cycles <= TIMEOUT + 20), 1);
    check_writes("timeout", 5);
    m2_run = 1'b1;

    // Reset in the middle of a restore write, then a clean save
    clear_log();
    pulse_start(1'b1);
    waited = 0;
    while (bus.sst_we_reg !== 1'b1 && waited < 300) begin
      tick(1);
      waited++;
    end
    chk("rstmid_we_seen", int'(bus.sst_we_reg === 1'b1), 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_act", int'(bus.sst_act), 0);
    chk("rstmid_we", int'(bus.sst_we_reg), 0);
    chk("rstmid_busy", int'(bus.busy), 0);
    tick(2);
    rst_n = 1'b1;
    clear_log();
    pulse_start(1'b0);
    wait_done("after_rst_save", 3000, 1'b0, cycles);
    chk("after_rst_count", save_cnt, 128);
    chk("after_rst_b0", int'(save_log[0]), 'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
